mux2x1_arb: RTL and testbench
=============================

Name: mux2x1_arb

Overview:
- Sequencing controller for the two-input control-word mux in a hierarchical-ring router stage.
- Inspects the valid bit of both incoming control words each cycle and picks a winner round-robin.
- Drives the mux select and registers the winning word onto a single output.
- Returns per-port grants so the losing upstream holds its word; honours a downstream stall.

Parameters:
- CTRL_W, 144, control-word width; equals the width of `control_w.
- VALID_BIT, 143, bit index of the valid flag inside a control word.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- port0_ci  in  `control_w  requester 0 word (ring-through traffic).
- port1_ci  in  `control_w  requester 1 word (injection traffic).
- stall_i  in  1  downstream cannot accept a new word this cycle.
- sel  out  1  mux select, combinational; 0 picks port0, 1 picks port1.
- gnt0  out  1  port0_ci consumed this cycle; combinational.
- gnt1  out  1  port1_ci consumed this cycle; combinational.
- port0_co  out  `control_w  registered winning word.
- last_o  out  1  registered round-robin pointer; identity of the last winner.
- gcnt0_o, gcnt1_o  out  CNT_W  grant counters; present only with the optional feature.

Behaviour:
- Reset: rst is sampled on the clock edge.
  - port0_co = 0, last_o = 1 (so port0 has first priority), counters = 0.
  - While rst is high: gnt0 = gnt1 = 0, sel = 0.
- Request derivation:
  - req0 = port0_ci[VALID_BIT] & ~rst.
  - req1 = port1_ci[VALID_BIT] & ~rst.
- Winner (combinational):
  - Only req0 → port0. Only req1 → port1.
  - Both → the port that is not last_o.
  - Neither → no winner, sel = last_o.
- Grants: gntN = 1 iff port N wins and stall_i = 0. At most one grant per cycle.
- sel:
  - Equals the winner index whenever there is a winner, including when stalled.
  - This keeps the mux stable during a stall.
- Output register, one-cycle latency:
  - stall_i = 0, winner exists: port0_co <= winning word; last_o <= winner.
  - stall_i = 0, no winner: port0_co <= 0 (bubble, valid bit clear); last_o unchanged.
  - stall_i = 1: port0_co and last_o hold; no grants; the pointer does not advance.
- Fairness:
  - Under continuous dual requests with no stall, grants strictly alternate.
  - Neither port ever waits more than one granted cycle.
- The word is passed through unmodified; the arbiter never alters payload bits.
- Reset mid-stream: the in-flight output word is discarded (port0_co = 0) and priority returns to port0.
- Simultaneous stall release and request change: the decision uses the current-cycle inputs only; no stale requests are remembered.

Optional Feature:
- Macro: MUX2X1_ARB_STATS_EN.
- Defined:
  - gcnt0_o and gcnt1_o exist.
  - Each increments by 1 on a cycle its grant is high.
  - Each saturates at 2^CNT_W-1, with no wrap.
  - Both clear on rst.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared defines.v holds:
  - `control_w.
  - The CTRL_W value 144.
  - VALID_BIT.
  - A `valid_f(x) extraction macro, reused by other ring blocks.
- One natural sub-module, rr_arb2:
  - Pure two-requester round-robin decision (req0, req1, last → win, any).
  - Reusable by the other hring arbiters.
- The output register, grant gating and counters stay in mux2x1_arb.

Test Plan:
- Reset release:
  - Stimulus: rst=1 for 2 cycles, then 0; no valid inputs.
  - Response: port0_co=0, last_o=1, gnt0=gnt1=0 throughout.
- Single requester:
  - Stimulus: port0_ci=144'h8000…0000_1850 (valid), port1 invalid.
  - Response: gnt0=1, sel=0; next cycle port0_co=8000…1850, last_o=0.
  - Then port1 valid alone → sel=1, gnt1=1.
- Contention:
  - Stimulus: both valid for 6 cycles (…1850 and …1851), no stall.
  - Response: grants alternate p0,p1,p0,p1,p0,p1; port0_co sequence matches, one cycle later.
- Stall:
  - Stimulus: both valid, stall_i=1 for 3 cycles mid-contention.
  - Response: port0_co and last_o frozen, gnt0=gnt1=0, sel steady at the pending winner.
  - After release, that same winner is granted first.
- Bubble and reset mid-stream:
  - Stimulus: inputs go invalid for 1 cycle, then valid; then assert rst.
  - Response: port0_co=0 after the idle cycle; last_o keeps its value.
  - On rst: port0_co cleared, and the first post-reset contention grants port0.
- Stats (MUX2X1_ARB_STATS_EN):
  - Stimulus: CNT_W=4, port1 alone valid for 20 cycles.
  - Response: gcnt1_o=15 (saturated), gcnt0_o=0.

Source files
------------

// File: rtl/mux2x1_arb_pkg.sv
// Shared types and constants for the hierarchical-ring control-word mux arbiter.
package mux2x1_arb_pkg;

  localparam int unsigned CTRL_W_DEF    = 144;
  localparam int unsigned VALID_BIT_DEF = 143;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  function automatic logic valid_f(input logic [CTRL_W_DEF-1:0] word);
    return word[VALID_BIT_DEF];
  endfunction

endpackage

// File: rtl/mux2x1_arb_rr_arb2.sv
// Pure two-requester round-robin decision; reusable by the other hring arbiters.
module rr_arb2
  import mux2x1_arb_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_e last,
  output port_e win,
  output logic  any
);

  always_comb begin
    any = req0 | req1;
    win = last;
    if (req0 && !req1) begin
      win = PORT0;
    end else if (req1 && !req0) begin
      win = PORT1;
    end else if (req0 && req1) begin
      win = (last == PORT0) ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/mux2x1_arb.sv
// Round-robin sequencer for the two-input control-word mux of a ring router stage.
// Optional grant counters are enabled with MUX2X1_ARB_STATS_EN.
module mux2x1_arb
  import mux2x1_arb_pkg::*;
#(
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned VALID_BIT = VALID_BIT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] port0_ci,
  input  logic [CTRL_W-1:0] port1_ci,
  input  logic              stall_i,
  output logic              sel,
  output logic              gnt0,
  output logic              gnt1,
  output logic [CTRL_W-1:0] port0_co,
`ifdef MUX2X1_ARB_STATS_EN
  output logic [CNT_W-1:0]  gcnt0_o,
  output logic [CNT_W-1:0]  gcnt1_o,
`endif
  output logic              last_o
);

  logic  req0;
  logic  req1;
  logic  any;
  port_e win;
  port_e last_q;

  assign req0 = port0_ci[VALID_BIT] & ~rst;
  assign req1 = port1_ci[VALID_BIT] & ~rst;

  rr_arb2 u_rr_arb2 (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  // sel follows the winner even while stalled so the mux stays put.
  always_comb begin
    sel  = 1'b0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      sel  = win;
      gnt0 = any & (win == PORT0) & ~stall_i;
      gnt1 = any & (win == PORT1) & ~stall_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port0_co <= '0;
      last_q   <= PORT1;
    end else if (!stall_i) begin
      if (any) begin
        port0_co <= (win == PORT1) ? port1_ci : port0_ci;
        last_q   <= win;
      end else begin
        port0_co <= '0;
      end
    end
  end

  assign last_o = last_q;

`ifdef MUX2X1_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0_o <= '0;
      gcnt1_o <= '0;
    end else begin
      if (gnt0 && (gcnt0_o != '1)) gcnt0_o <= gcnt0_o + 1'b1;
      if (gnt1 && (gcnt1_o != '1)) gcnt1_o <= gcnt1_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2x1_arb.sv
// Directed bench for mux2x1_arb; grant counters are checked when MUX2X1_ARB_STATS_EN is defined.
module tb_mux2x1_arb;

  localparam int unsigned W = 144;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] port0_ci;
  logic [W-1:0] port1_ci;
  logic         stall_i;
  logic         sel;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] port0_co;
  logic         last_o;
`ifdef MUX2X1_ARB_STATS_EN
  logic [3:0]   gcnt0_o;
  logic [3:0]   gcnt1_o;
`endif

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  mux2x1_arb #(
    .CTRL_W    (144),
    .VALID_BIT (143),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .port0_ci (port0_ci),
    .port1_ci (port1_ci),
    .stall_i  (stall_i),
    .sel      (sel),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .port0_co (port0_co),
`ifdef MUX2X1_ARB_STATS_EN
    .gcnt0_o  (gcnt0_o),
    .gcnt1_o  (gcnt1_o),
`endif
    .last_o   (last_o)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mkw(input logic v, input logic [15:0] lo);
    logic [W-1:0] w;
    w = '0;
    w[143] = v;
    w[15:0] = lo;
    return w;
  endfunction

  // Advance one clock; outputs settle 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Combinational checks after inputs settle.
  task automatic comb(input string tag, input logic s, input logic g0, input logic g1);
    #1;
    chk({tag, ".sel"}, W'(sel), W'(s));
    chk({tag, ".gnt0"}, W'(gnt0), W'(g0));
    chk({tag, ".gnt1"}, W'(gnt1), W'(g1));
  endtask

  task automatic regs(input string tag, input logic [W-1:0] co, input logic l);
    chk({tag, ".co"}, port0_co, co);
    chk({tag, ".last"}, W'(last_o), W'(l));
  endtask

  logic [W-1:0] a, b, inv, big;

  initial begin
    a   = mkw(1'b1, 16'h1850);
    b   = mkw(1'b1, 16'h1851);
    inv = mkw(1'b0, 16'h1234);
    big = '1;

    rst = 1'b1; stall_i = 1'b0; port0_ci = '0; port1_ci = '0;
    comb("rst0", 1'b0, 1'b0, 1'b0);
    step();
    regs("rst0", '0, 1'b1);
    port0_ci = a;
    comb("rst1", 1'b0, 1'b0, 1'b0);
    step();
    regs("rst1", '0, 1'b1);

    rst = 1'b0; port0_ci = inv; port1_ci = '0;
    comb("idle", 1'b1, 1'b0, 1'b0);
    step();
    regs("idle", '0, 1'b1);

    port0_ci = a;
    comb("p0only", 1'b0, 1'b1, 1'b0);
    step();
    regs("p0only", a, 1'b0);

    port0_ci = inv; port1_ci = b;
    comb("p1only", 1'b1, 1'b0, 1'b1);
    step();
    regs("p1only", b, 1'b1);

    port0_ci = a; port1_ci = b;
    for (int i = 0; i < 6; i++) begin
      comb($sformatf("cont%0d", i), (i % 2) == 1, (i % 2) == 0, (i % 2) == 1);
      step();
      regs($sformatf("cont%0d", i), ((i % 2) == 1) ? b : a, (i % 2) == 1);
    end

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      comb($sformatf("stall%0d", i), 1'b0, 1'b0, 1'b0);
      step();
      regs($sformatf("stall%0d", i), b, 1'b1);
    end
    stall_i = 1'b0;
    comb("release", 1'b0, 1'b1, 1'b0);
    step();
    regs("release", a, 1'b0);

    port0_ci = inv; port1_ci = inv;
    comb("bubble", 1'b0, 1'b0, 1'b0);
    step();
    regs("bubble", '0, 1'b0);
    port0_ci = a; port1_ci = b;
    comb("resume", 1'b1, 1'b0, 1'b1);
    step();
    regs("resume", b, 1'b1);

    stall_i = 1'b1; port0_ci = inv; port1_ci = b;
    comb("stall_p1", 1'b1, 1'b0, 1'b0);
    step();
    regs("stall_p1", b, 1'b1);
    stall_i = 1'b0; port0_ci = a; port1_ci = inv;
    comb("nostale", 1'b0, 1'b1, 1'b0);
    step();
    regs("nostale", a, 1'b0);

    port0_ci = inv; port1_ci = big;
    comb("payload", 1'b1, 1'b0, 1'b1);
    step();
    regs("payload", big, 1'b1);

    port0_ci = a; port1_ci = b;
    comb("pre_rst", 1'b0, 1'b1, 1'b0);
    step();
    regs("pre_rst", a, 1'b0);
    rst = 1'b1;
    comb("mid_rst", 1'b0, 1'b0, 1'b0);
    step();
    regs("mid_rst", '0, 1'b1);
    rst = 1'b0;
    comb("post_rst", 1'b0, 1'b1, 1'b0);
    step();
    regs("post_rst", a, 1'b0);

`ifdef MUX2X1_ARB_STATS_EN
    rst = 1'b1;
    step();
    chk("cnt_rst0", W'(gcnt0_o), W'(0));
    chk("cnt_rst1", W'(gcnt1_o), W'(0));
    rst = 1'b0; port0_ci = inv; port1_ci = b;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 4) chk("cnt1_5", W'(gcnt1_o), W'(5));
    end
    chk("cnt1_sat", W'(gcnt1_o), W'(15));
    chk("cnt0_zero", W'(gcnt0_o), W'(0));
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
